// File: rtl/data_memory_me.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_me
// Brief    : MEM-stage little-endian data memory with registered load result.
// Revision : 1.0
// ============================================================================
module data_memory_me #(
    parameter int DEPTH = 1024
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        MisalignErr
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_data_rd;
    logic              r_err;

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic              w_err;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_we;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic              w_unused_addr;

    assign w_idx         = Address[ADDR_W+1:2];
    assign w_lane        = Address[1:0];
    assign w_unused_addr = ^Address[31:ADDR_W+2];

    always_comb begin
        w_err = 1'b0;
        case (DMCtrl)
            c_LB, c_LBU: w_err = 1'b0;
            c_LH, c_LHU: w_err = w_lane[0];
            c_LW:        w_err = (w_lane != 2'b00);
            default:     w_err = 1'b1;
        endcase
    end

    // funct3[2] only selects load extension, so stores decode on funct3[1:0].
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'h0;
        case (DMCtrl[1:0])
            2'b00: begin
                w_be            = 4'b0001 << w_lane;
                w_wdata         = {4{DataWr[7:0]}};
            end
            2'b01: begin
                w_be            = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata         = {2{DataWr[15:0]}};
            end
            2'b10: begin
                w_be            = 4'b1111;
                w_wdata         = DataWr;
            end
            default: begin
                w_be            = 4'b0000;
                w_wdata         = 32'h0;
            end
        endcase
    end

    assign w_we = Rst_n && !Flush && !Stall && DMWr && !w_err;

    always_ff @(posedge Clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[8*w_lane +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = 32'h0;
        case (DMCtrl)
            c_LB:    w_load = {{24{w_byte[7]}}, w_byte};
            c_LH:    w_load = {{16{w_half[15]}}, w_half};
            c_LW:    w_load = w_word;
            c_LBU:   w_load = {24'h0, w_byte};
            c_LHU:   w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_data_rd <= 32'h0;
            r_err     <= 1'b0;
        end else if (Flush) begin
            r_data_rd <= 32'h0;
            r_err     <= 1'b0;
        end else if (!Stall) begin
            r_data_rd <= (DMWr || w_err) ? 32'h0 : w_load;
            r_err     <= w_err;
        end
    end

    assign DataRd      = r_data_rd;
    assign MisalignErr = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_me.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_me
// Brief    : Directed self-checking bench for data_memory_me.
// Revision : 1.0
// ============================================================================
module tb_data_memory_me;

    localparam int DEPTH = 1024;

    logic        Clk;
    logic        Rst_n;
    logic        Stall;
    logic        Flush;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
    logic        MisalignErr;

    int n_checks = 0;
    int n_fails  = 0;

    data_memory_me #(.DEPTH(DEPTH)) u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Stall       (Stall),
        .Flush       (Flush),
        .Address     (Address),
        .DataWr      (DataWr),
        .DMWr        (DMWr),
        .DMCtrl      (DMCtrl),
        .DataRd      (DataRd),
        .MisalignErr (MisalignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one access, clock it, and return 1ns after the edge.
    task automatic op(input logic wr, input logic [2:0] ctrl,
                      input logic [31:0] addr, input logic [31:0] data);
        DMWr    = wr;
        DMCtrl  = ctrl;
        Address = addr;
        DataWr  = data;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
        DMWr = 1'b0; DMCtrl = 3'b010; Address = 32'h0; DataWr = 32'h0;
        op(1'b0, 3'b010, 32'h0, 32'h0);
        op(1'b0, 3'b010, 32'h0, 32'h0);
        check("reset_data", DataRd, 32'h0);
        check("reset_err", {31'h0, MisalignErr}, 32'h0);
        Rst_n = 1'b1;

        // Word store then load
        op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_data0", DataRd, 32'h0);
        check("sw_err0", {31'h0, MisalignErr}, 32'h0);
        op(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_10", DataRd, 32'hDEADBEEF);
        check("lw_10_err", {31'h0, MisalignErr}, 32'h0);

        // Byte store into lane 1, upper DataWr bits must be ignored
        op(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A);
        op(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_after_sb", DataRd, 32'hDEAD5AEF);
        op(1'b0, 3'b000, 32'h13, 32'h0);
        check("lb_13", DataRd, 32'hFFFFFFDE);
        op(1'b0, 3'b100, 32'h13, 32'h0);
        check("lbu_13", DataRd, 32'h000000DE);
        op(1'b0, 3'b000, 32'h10, 32'h0);
        check("lb_10", DataRd, 32'hFFFFFFEF);

        // Half loads and misalignment
        op(1'b0, 3'b001, 32'h12, 32'h0);
        check("lh_12", DataRd, 32'hFFFFDEAD);
        op(1'b0, 3'b101, 32'h12, 32'h0);
        check("lhu_12", DataRd, 32'h0000DEAD);
        op(1'b0, 3'b001, 32'h10, 32'h0);
        check("lh_10", DataRd, 32'h00005AEF);
        op(1'b0, 3'b001, 32'h11, 32'h0);
        check("lh_11_data", DataRd, 32'h0);
        check("lh_11_err", {31'h0, MisalignErr}, 32'h1);
        op(1'b0, 3'b011, 32'h10, 32'h0);
        check("illegal_ctrl_data", DataRd, 32'h0);
        check("illegal_ctrl_err", {31'h0, MisalignErr}, 32'h1);
        op(1'b0, 3'b010, 32'h10, 32'h0);
        check("err_clears", {31'h0, MisalignErr}, 32'h0);

        // Misaligned word store must not write
        op(1'b1, 3'b010, 32'h20, 32'h01020304);
        op(1'b1, 3'b010, 32'h22, 32'h12345678);
        check("sw_mis_err", {31'h0, MisalignErr}, 32'h1);
        op(1'b0, 3'b010, 32'h20, 32'h0);
        check("lw_20_unchanged", DataRd, 32'h01020304);

        // Stall holds registered outputs and blocks stores
        op(1'b0, 3'b010, 32'h10, 32'h0);
        Stall = 1'b1;
        op(1'b0, 3'b010, 32'h20, 32'h0);
        check("stall_hold1", DataRd, 32'hDEAD5AEF);
        op(1'b0, 3'b010, 32'h20, 32'h0);
        check("stall_hold2", DataRd, 32'hDEAD5AEF);
        Stall = 1'b0;
        op(1'b0, 3'b001, 32'h11, 32'h0);
        Stall = 1'b1;
        op(1'b1, 3'b010, 32'h20, 32'hFFFFFFFF);
        check("stall_err_hold", {31'h0, MisalignErr}, 32'h1);
        Stall = 1'b0;
        op(1'b0, 3'b010, 32'h20, 32'h0);
        check("stall_sw_blocked", DataRd, 32'h01020304);

        // Flush clears outputs and blocks stores
        op(1'b1, 3'b010, 32'h30, 32'h0BADBEEF);
        op(1'b0, 3'b001, 32'h11, 32'h0);
        Flush = 1'b1;
        Stall = 1'b1;
        op(1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
        check("flush_err", {31'h0, MisalignErr}, 32'h0);
        Flush = 1'b0;
        Stall = 1'b0;
        op(1'b0, 3'b010, 32'h30, 32'h0);
        check("flush_sw_blocked", DataRd, 32'h0BADBEEF);

        // Reset clears outputs, loses the store in its cycle, keeps the array
        Rst_n = 1'b0;
        op(1'b1, 3'b010, 32'h30, 32'h99999999);
        check("rst_data", DataRd, 32'h0);
        Rst_n = 1'b1;
        op(1'b0, 3'b010, 32'h30, 32'h0);
        check("rst_sw_lost", DataRd, 32'h0BADBEEF);
        op(1'b0, 3'b010, 32'h10, 32'h0);
        check("rst_retained", DataRd, 32'hDEAD5AEF);

        // Address wrap and half store into upper lanes
        op(1'b1, 3'b010, DEPTH * 4 + 32'h4, 32'h11111111);
        op(1'b0, 3'b010, 32'h4, 32'h0);
        check("wrap_lw", DataRd, 32'h11111111);
        op(1'b1, 3'b101, 32'h6, 32'hABCD2222);
        op(1'b0, 3'b010, 32'h4, 32'h0);
        check("sh_upper", DataRd, 32'h22221111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
